// File: rtl/handshake_arbiter.sv
// handshake_arbiter: two-requester four-phase handshake arbiter in front of one shared stage
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_in1, req_in2    four-phase requests from requesters 1 and 2
//   ack_out1, ack_out2  four-phase acknowledges back to requesters 1 and 2
//   req_out, ack_in     four-phase request/acknowledge pair to the shared stage
//   grant               one-hot owner of the shared stage (bit0 = requester 1), 0 when idle
//   busy                high whenever a transaction is in flight
//   timeout_err         sticky flag: stage did not acknowledge within TIMEOUT_CYCLES (0 disables)
// Macro HANDSHAKE_ARBITER_RR_EN: round-robin on simultaneous requests; otherwise requester 1 has priority.
module handshake_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in1,
  input  logic       req_in2,
  output logic       ack_out1,
  output logic       ack_out2,
  output logic       req_out,
  input  logic       ack_in,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
  state_t state, state_n;
  logic [1:0] win, grant_n;
  logic req_out_n, ack1_n, ack2_n, err_n, granted_req;
  logic [CW-1:0] cnt, cnt_n;
`ifdef HANDSHAKE_ARBITER_RR_EN
  logic last2;
  assign win = (req_in1 && req_in2) ? (last2 ? 2'b01 : 2'b10) : {req_in2, req_in1};
  // Reset to "requester 2 granted last" so requester 1 wins the first tie.
  always_ff @(posedge clk or posedge rst)
    if (rst) last2 <= 1'b1;
    else if (state == IDLE && win != 2'b00) last2 <= win[1];
`else
  assign win = req_in1 ? 2'b01 : {req_in2, 1'b0};
`endif
  // Only the owner's request can advance ACK; an early drop during REQ just waits for ack_in.
  assign granted_req = |(grant & {req_in2, req_in1});
  always_comb begin
    state_n = state;
    grant_n = grant;
    req_out_n = req_out;
    ack1_n = ack_out1;
    ack2_n = ack_out2;
    case (state)
      IDLE: if (win != 2'b00) begin
        state_n = REQ;
        grant_n = win;
        req_out_n = 1'b1;
      end
      REQ: if (ack_in) begin
        state_n = ACK;
        ack1_n = grant[0];
        ack2_n = grant[1];
      end
      ACK: if (!granted_req) begin
        state_n = REL;
        req_out_n = 1'b0;
      end
      REL: if (!ack_in) begin
        state_n = IDLE;
        grant_n = 2'b00;
        ack1_n = 1'b0;
        ack2_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // Counter holds the number of completed cycles in REQ; it saturates at all-ones.
  assign cnt_n = (state == IDLE && state_n == REQ) ? '0 :
                 (state == REQ && cnt != '1) ? cnt + 1'b1 : cnt;
  assign err_n = timeout_err | (TIMEOUT_CYCLES != 0 && state == REQ && cnt == CW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      req_out <= 1'b0;
      ack_out1 <= 1'b0;
      ack_out2 <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      req_out <= req_out_n;
      ack_out1 <= ack1_n;
      ack_out2 <= ack2_n;
      busy <= state_n != IDLE;
      timeout_err <= err_n;
      cnt <= cnt_n;
    end
endmodule
